// File: rtl/wdt_pkg.sv
// Shared definitions for the windowed watchdog: state encoding and default timeout.
package wdt_pkg;

    localparam int STATE_W             = 2;
    localparam int DEFAULT_TIMEOUT_VAL = 100000;

    typedef enum logic [STATE_W-1:0] {
        ST_DISABLED  = 2'd0,
        ST_RUN       = 2'd1,
        ST_EXPIRED   = 2'd2,
        ST_RESET_REQ = 2'd3
    } wdt_state_t;

endpackage

// File: rtl/wdt_window_rise_detect.sv
// Rising-edge detector for a synchronous level input; rise is combinational from
// the current input and its registered copy.
module rise_detect (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic rise
);

    logic din_d_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            din_d_reg <= 1'b0;
        end else begin
            din_d_reg <= din;
        end
    end

    assign rise = din & ~din_d_reg;

endmodule

// File: rtl/wdt_window.sv
// Windowed watchdog: programmable timeout, early-pet window, pre-warning pulse
// and two-stage escalation (sticky irq, then sticky reset request).
module wdt_window
    import wdt_pkg::*;
#(
    parameter int CNT_WIDTH       = 32,
    parameter int DEFAULT_TIMEOUT = DEFAULT_TIMEOUT_VAL
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 enable,
    input  logic [CNT_WIDTH-1:0] timeout_cnt,
    input  logic [CNT_WIDTH-1:0] window_cnt,
    input  logic [CNT_WIDTH-1:0] warn_cnt,
    input  logic                 pet,
    input  logic                 irq_clr,
    output logic                 irq,
    output logic                 warn,
    output logic                 early_pet,
    output logic                 rst_req,
    output logic [STATE_W-1:0]   state,
    output logic [CNT_WIDTH-1:0] count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_DEF  = CNT_WIDTH'(DEFAULT_TIMEOUT);

    wdt_state_t           state_reg;
    logic [CNT_WIDTH-1:0] count_reg;
    logic [CNT_WIDTH-1:0] timeout_reg;
    logic [CNT_WIDTH-1:0] window_reg;
    logic [CNT_WIDTH-1:0] warn_cnt_reg;
    logic                 irq_reg;
    logic                 warn_reg;
    logic                 early_pet_reg;
    logic                 rst_req_reg;

    logic pet_edge;
    logic pet_early;
    logic at_limit;
    logic warn_hit;

    rise_detect u_pet_edge (
        .clk    (clk),
        .resetn (resetn),
        .din    (pet),
        .rise   (pet_edge)
    );

    // The shadow timeout is never zero once latched, so the subtraction cannot wrap.
    assign at_limit  = (count_reg == (timeout_reg - CNT_ONE));
    assign pet_early = pet_edge && (window_reg != CNT_ZERO) && (count_reg < window_reg);
    assign warn_hit  = (warn_cnt_reg != CNT_ZERO) && (warn_cnt_reg < timeout_reg)
                       && (count_reg == warn_cnt_reg);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= ST_DISABLED;
            count_reg     <= CNT_ZERO;
            timeout_reg   <= CNT_ZERO;
            window_reg    <= CNT_ZERO;
            warn_cnt_reg  <= CNT_ZERO;
            irq_reg       <= 1'b0;
            warn_reg      <= 1'b0;
            early_pet_reg <= 1'b0;
            rst_req_reg   <= 1'b0;
        end else begin
            warn_reg      <= 1'b0;
            early_pet_reg <= 1'b0;
            case (state_reg)
                ST_DISABLED: begin
                    count_reg <= CNT_ZERO;
                    if (irq_clr) begin
                        irq_reg <= 1'b0;
                    end
                    if (enable) begin
                        timeout_reg  <= (timeout_cnt == CNT_ZERO) ? CNT_DEF : timeout_cnt;
                        window_reg   <= window_cnt;
                        warn_cnt_reg <= warn_cnt;
                        state_reg    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (irq_clr) begin
                        irq_reg <= 1'b0;
                    end
                    if (!enable) begin
                        state_reg <= ST_DISABLED;
                        count_reg <= CNT_ZERO;
                    end else begin
                        warn_reg <= warn_hit;
                        if (pet_early) begin
                            early_pet_reg <= 1'b1;
                            irq_reg       <= 1'b1;
                            state_reg     <= ST_EXPIRED;
                            count_reg     <= CNT_ZERO;
                        end else if (pet_edge) begin
                            count_reg <= CNT_ZERO;
                        end else if (at_limit) begin
                            irq_reg   <= 1'b1;
                            state_reg <= ST_EXPIRED;
                            count_reg <= CNT_ZERO;
                        end else begin
                            count_reg <= count_reg + CNT_ONE;
                        end
                    end
                end
                ST_EXPIRED: begin
                    if (!enable) begin
                        // irq survives the disable; only irq_clr drops it.
                        if (irq_clr) begin
                            irq_reg <= 1'b0;
                        end
                        state_reg <= ST_DISABLED;
                        count_reg <= CNT_ZERO;
                    end else if (irq_clr) begin
                        irq_reg   <= 1'b0;
                        state_reg <= ST_RUN;
                        count_reg <= CNT_ZERO;
                    end else if (at_limit) begin
                        rst_req_reg <= 1'b1;
                        state_reg   <= ST_RESET_REQ;
                    end else begin
                        count_reg <= count_reg + CNT_ONE;
                    end
                end
                default: begin
                    state_reg <= ST_RESET_REQ;
                end
            endcase
        end
    end

    assign state     = state_reg;
    assign count     = count_reg;
    assign irq       = irq_reg;
    assign warn      = warn_reg;
    assign early_pet = early_pet_reg;
    assign rst_req   = rst_req_reg;

endmodule

// File: tb/tb_wdt_window.sv
// Directed bench for wdt_window: hand-computed expectations for each scenario.
module tb_wdt_window;
    import wdt_pkg::*;

    localparam int CW  = 32;
    localparam int DEF = 50;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          enable = 1'b0;
    logic          pet = 1'b0;
    logic          irq_clr = 1'b0;
    logic [CW-1:0] timeout_cnt = '0;
    logic [CW-1:0] window_cnt = '0;
    logic [CW-1:0] warn_cnt = '0;
    logic          irq, warn, early_pet, rst_req;
    logic [1:0]    state;
    logic [CW-1:0] count;

    int errors = 0;
    int checks = 0;
    int maxc, irqs, nw;

    always #5 clk = ~clk;

    wdt_window #(.CNT_WIDTH(CW), .DEFAULT_TIMEOUT(DEF)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .enable      (enable),
        .timeout_cnt (timeout_cnt),
        .window_cnt  (window_cnt),
        .warn_cnt    (warn_cnt),
        .pet         (pet),
        .irq_clr     (irq_clr),
        .irq         (irq),
        .warn        (warn),
        .early_pet   (early_pet),
        .rst_req     (rst_req),
        .state       (state),
        .count       (count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reset, program config, enable; returns one cycle after RUN entry (count=0).
    task automatic restart(input int to, input int win, input int wr);
        resetn = 1'b0; enable = 1'b0; pet = 1'b0; irq_clr = 1'b0;
        tick(1);
        resetn = 1'b1;
        timeout_cnt = CW'(to); window_cnt = CW'(win); warn_cnt = CW'(wr);
        enable = 1'b1;
        tick(1);
    endtask

    initial begin
        #1;
        check("rst_state", state, 0);
        check("rst_count", count, 0);
        check("rst_irq", irq, 0);
        check("rst_warn", warn, 0);
        check("rst_early", early_pet, 0);
        check("rst_rstreq", rst_req, 0);
        resetn = 1'b1;
        tick(3);
        check("dis_state", state, 0);
        check("dis_count", count, 0);

        $display("scenario: plain timeout 10");
        restart(10, 0, 0);
        check("t1_run", state, 1);
        check("t1_cnt0", count, 0);
        tick(9);
        check("t1_cnt9", count, 9);
        check("t1_noirq", irq, 0);
        tick(1);
        check("t1_irq", irq, 1);
        check("t1_exp", state, 2);
        check("t1_cnt", count, 0);
        enable = 1'b0;
        tick(1);
        check("t1_dis", state, 0);
        check("t1_irq_kept", irq, 1);
        irq_clr = 1'b1;
        tick(1);
        irq_clr = 1'b0;
        check("t1_irq_clr_dis", irq, 0);

        $display("scenario: periodic pet every 8");
        restart(10, 0, 0);
        maxc = 0; irqs = 0;
        for (int i = 0; i < 100; i++) begin
            pet = ((i % 8) == 7);
            tick(1);
            if (int'(count) > maxc) maxc = int'(count);
            if (irq) irqs++;
        end
        pet = 1'b0;
        check("t2_max", maxc, 7);
        check("t2_irqs", irqs, 0);
        check("t2_state", state, 1);

        $display("scenario: early pet window 5");
        restart(20, 5, 0);
        tick(3);
        check("t3_cnt3", count, 3);
        pet = 1'b1;
        tick(1);
        check("t3_early", early_pet, 1);
        check("t3_irq", irq, 1);
        check("t3_state", state, 2);
        check("t3_cnt", count, 0);
        pet = 1'b0;
        tick(1);
        check("t3_early_pulse", early_pet, 0);
        check("t3_exp_cnt", count, 1);
        restart(20, 5, 0);
        tick(5);
        pet = 1'b1;
        tick(1);
        pet = 1'b0;
        check("t3_ok_cnt", count, 0);
        check("t3_ok_irq", irq, 0);
        check("t3_ok_early", early_pet, 0);
        check("t3_ok_state", state, 1);

        $display("scenario: irq_clr and escalation");
        restart(10, 0, 0);
        tick(10);
        check("t4_exp", state, 2);
        tick(4);
        check("t4_cnt4", count, 4);
        irq_clr = 1'b1;
        tick(1);
        irq_clr = 1'b0;
        check("t4_clr_irq", irq, 0);
        check("t4_clr_state", state, 1);
        check("t4_clr_cnt", count, 0);
        tick(10);
        check("t4_exp2", state, 2);
        check("t4_irq2", irq, 1);
        tick(9);
        check("t4_cnt9", count, 9);
        check("t4_norst", rst_req, 0);
        tick(1);
        check("t4_rstreq", rst_req, 1);
        check("t4_rr_state", state, 3);
        irq_clr = 1'b1; enable = 1'b0;
        tick(2);
        irq_clr = 1'b0;
        check("t4_term_state", state, 3);
        check("t4_term_irq", irq, 1);
        check("t4_term_rr", rst_req, 1);
        resetn = 1'b0;
        #2;
        check("t4_async_state", state, 0);
        check("t4_async_irq", irq, 0);
        check("t4_async_rr", rst_req, 0);
        check("t4_async_cnt", count, 0);
        resetn = 1'b1;

        $display("scenario: warn at 12 of 16");
        restart(16, 0, 12);
        tick(12);
        check("t5_cnt12", count, 12);
        check("t5_nowarn", warn, 0);
        tick(1);
        check("t5_warn", warn, 1);
        check("t5_cnt13", count, 13);
        tick(1);
        check("t5_warn_pulse", warn, 0);
        pet = 1'b1;
        tick(1);
        pet = 1'b0;
        nw = 0;
        for (int i = 0; i < 11; i++) begin
            tick(1);
            if (warn) nw++;
        end
        check("t5_cnt11", count, 11);
        pet = 1'b1;
        tick(1);
        pet = 1'b0;
        if (warn) nw++;
        tick(1);
        if (warn) nw++;
        check("t5_nowarn_period", nw, 0);
        tick(11);
        check("t5_cnt12b", count, 12);
        tick(1);
        check("t5_warn_again", warn, 1);

        $display("scenario: default timeout");
        restart(0, 0, 0);
        tick(49);
        check("c1_noirq", irq, 0);
        tick(1);
        check("c1_irq", irq, 1);
        check("c1_state", state, 2);

        $display("scenario: timeout change mid-run");
        restart(10, 0, 0);
        tick(2);
        timeout_cnt = CW'(3);
        tick(7);
        check("c2_noirq", irq, 0);
        tick(1);
        check("c2_irq", irq, 1);

        $display("scenario: pet at last count");
        restart(10, 0, 0);
        tick(9);
        pet = 1'b1;
        tick(1);
        pet = 1'b0;
        check("c3_irq", irq, 0);
        check("c3_state", state, 1);
        check("c3_cnt", count, 0);

        $display("scenario: disable at last count");
        restart(10, 0, 0);
        tick(9);
        enable = 1'b0;
        tick(1);
        check("c4_state", state, 0);
        check("c4_irq", irq, 0);
        check("c4_cnt", count, 0);

        $display("scenario: window beyond timeout");
        restart(5, 8, 0);
        tick(4);
        pet = 1'b1;
        tick(1);
        pet = 1'b0;
        check("c5_early", early_pet, 1);
        check("c5_state", state, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
